// File: rtl/vga_scanout_if.sv
// Frame-memory read port and VGA connector signals of the scanout block.
// master = scanout engine, slave = frame memory / display side.
interface vga_scanout_if;
    logic [18:0] src_addr;
    logic        src_rd;
    logic [15:0] src_data;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        de;
    logic        frame_start;
    logic        vblank;

    modport master (
        output src_addr, src_rd,
        input  src_data,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, de, frame_start, vblank
    );

    modport slave (
        input  src_addr, src_rd,
        output src_data,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, de, frame_start, vblank
    );
endinterface

// File: rtl/vga_scanout.sv
// Raster scanout: reads RGB565 pixels from frame memory in raster order and
// drives 4-bit VGA RGB with sync, display-enable, vblank and frame_start.
module vga_scanout #(
    parameter int CLK_DIV = 4,
    parameter int RD_LAT  = 1,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic          clk,
    input  logic          rst,
    vga_scanout_if.master bus
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DW    = $clog2(CLK_DIV);
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_CAP  = DW'(RD_LAT);
    localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] HS_ON    = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_OFF   = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] VS_ON    = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_OFF   = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [18:0]   ADDR_LAST = 19'(H_VIS * V_VIS - 1);

    logic [DW-1:0] div_reg;
    logic [HW-1:0] hcnt_reg, hcnt_next;
    logic [VW-1:0] vcnt_reg, vcnt_next;
    logic [18:0]   addr_reg;
    logic [15:0]   pix_reg;
    logic [3:0]    r_reg, g_reg, b_reg;
    logic          hs_reg, vs_reg, de_reg, fs_reg, vblank_reg;

    logic tick, visible, frame_wrap;

    assign tick       = (div_reg == DIV_LAST);
    assign visible    = (hcnt_reg < H_VIS_C) && (vcnt_reg < V_VIS_C);
    assign frame_wrap = tick && (hcnt_reg == H_LAST) && (vcnt_reg == V_LAST);

    always_comb begin
        hcnt_next = hcnt_reg + 1'b1;
        vcnt_next = vcnt_reg;
        if (hcnt_reg == H_LAST) begin
            hcnt_next = '0;
            vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg    <= '0;
            hcnt_reg   <= '0;
            vcnt_reg   <= '0;
            addr_reg   <= '0;
            pix_reg    <= '0;
            r_reg      <= '0;
            g_reg      <= '0;
            b_reg      <= '0;
            hs_reg     <= 1'b1;
            vs_reg     <= 1'b1;
            de_reg     <= 1'b0;
            fs_reg     <= 1'b0;
            vblank_reg <= 1'b0;
        end else begin
            div_reg <= tick ? '0 : div_reg + 1'b1;
            fs_reg  <= frame_wrap;
            // Read data for this pixel period is valid exactly RD_LAT clocks after the strobe.
            if (div_reg == DIV_CAP) begin
                pix_reg <= bus.src_data;
            end
            if (tick) begin
                hcnt_reg <= hcnt_next;
                vcnt_reg <= vcnt_next;
                if (frame_wrap) begin
                    addr_reg <= '0;
                end else if (visible && addr_reg != ADDR_LAST) begin
                    addr_reg <= addr_reg + 1'b1;
                end
                // Outputs describe the pixel period that just ended: one pixel of latency.
                de_reg     <= visible;
                r_reg      <= visible ? pix_reg[15:12] : 4'h0;
                g_reg      <= visible ? pix_reg[10:7]  : 4'h0;
                b_reg      <= visible ? pix_reg[4:1]   : 4'h0;
                hs_reg     <= !((hcnt_reg >= HS_ON) && (hcnt_reg < HS_OFF));
                vs_reg     <= !((vcnt_reg >= VS_ON) && (vcnt_reg < VS_OFF));
                vblank_reg <= (vcnt_next >= V_VIS_C);
            end
        end
    end

    // Strobe is combinational so the very first period after reset release is fetched.
    assign bus.src_rd      = !rst && (div_reg == '0) && visible;
    assign bus.src_addr    = addr_reg;
    assign bus.vga_r       = r_reg;
    assign bus.vga_g       = g_reg;
    assign bus.vga_b       = b_reg;
    assign bus.vga_hs      = hs_reg;
    assign bus.vga_vs      = vs_reg;
    assign bus.de          = de_reg;
    assign bus.frame_start = fs_reg;
    assign bus.vblank      = vblank_reg;
endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken 15x8 raster with RD_LAT=2.
// A producer queues per-clock expectations; a negedge monitor pops and compares.
module tb_vga_scanout;
    localparam int CLK_DIV = 4;
    localparam int RD_LAT  = 2;
    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int H_TOT = HV + HF + HS + HB;       // 15
    localparam int V_TOT = VV + VF + VS + VB;       // 8
    localparam int FRAME = H_TOT * V_TOT;           // 120 ticks
    localparam int FRAME_CLK = FRAME * CLK_DIV;     // 480 clk

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_scanout_if bus ();

    vga_scanout #(
        .CLK_DIV(CLK_DIV), .RD_LAT(RD_LAT),
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Line 1 returns 0xF81F; everything else returns {a[4:0], a[5:0], a[4:0]}.
    function automatic logic [15:0] mem_word(int a);
        if (a >= HV && a < 2 * HV) return 16'hF81F;
        return {a[4:0], a[5:0], a[4:0]};
    endfunction

    logic [15:0] pipe [RD_LAT];
    always @(posedge clk) begin
        pipe[0] <= bus.src_rd ? mem_word(int'(bus.src_addr)) : 16'h0BAD;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.src_data = pipe[RD_LAT-1];

    typedef struct {
        int          c;
        int          ep;
        logic        rd;
        logic [18:0] addr;
        logic [3:0]  r, g, b;
        logic        hs, vs, de, fs, vb;
    } exp_t;

    exp_t sb[$];

    // Expected outputs during clock c after reset release, from global tick arithmetic.
    function automatic exp_t model(int c, int e);
        exp_t x;
        int n, pos, h, v, pp, ph, pv;
        logic [15:0] w;
        x.c = c; x.ep = e;
        n = c / CLK_DIV; pos = n % FRAME; h = pos % H_TOT; v = pos / H_TOT;
        x.rd   = (c % CLK_DIV == 0) && (h < HV) && (v < VV);
        x.addr = 19'(v * HV + h);
        x.vb   = (v >= VV);
        x.fs   = (c % CLK_DIV == 0) && (n > 0) && (pos == 0);
        x.r = 4'h0; x.g = 4'h0; x.b = 4'h0; x.hs = 1'b1; x.vs = 1'b1; x.de = 1'b0;
        if (n > 0) begin
            pp = (n - 1) % FRAME; ph = pp % H_TOT; pv = pp / H_TOT;
            x.de = (ph < HV) && (pv < VV);
            w = mem_word(pv * HV + ph);
            if (x.de) begin
                x.r = w[15:12]; x.g = w[10:7]; x.b = w[4:1];
            end
            x.hs = !((ph >= HV + HF) && (ph < HV + HF + HS));
            x.vs = !((pv >= VV + VF) && (pv < VV + VF + VS));
        end
        return x;
    endfunction

    // Producer
    int cyc = 0, ep = 0;
    bit running = 0;
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (rst) begin
                sb.delete();
                running = 0;
            end else if (!running) begin
                running = 1; ep++; cyc = 0;
                sb.push_back(model(0, ep));
            end else begin
                cyc++;
                sb.push_back(model(cyc, ep));
            end
        end
    end

    // Monitor
    int n_cmp = 0, n_fail = 0;
    bit do_final = 0, final_done = 0;
    int max_addr = -1, prev_rd_addr = -1, last_before = -1;
    int rd_f1 = 0, rd_in_vb = 0, hs_low_l0 = 0, first_hs_low = -1, vs_low_f1 = 0;
    int px5 = -1, px_f = -1;
    int fs_times[$];

    task automatic chk(string name, int act, int expv, int c);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at clk %0d", name, act, act, expv, expv, c);
        end
    endtask

    initial begin
        exp_t e;
        bit f1;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_hs", int'(bus.vga_hs), 1, -1);
                chk("rst_vs", int'(bus.vga_vs), 1, -1);
                chk("rst_rgb", int'({bus.vga_r, bus.vga_g, bus.vga_b}), 0, -1);
                chk("rst_de", int'(bus.de), 0, -1);
                chk("rst_fs", int'(bus.frame_start), 0, -1);
                chk("rst_vblank", int'(bus.vblank), 0, -1);
                chk("rst_src_rd", int'(bus.src_rd), 0, -1);
                chk("rst_src_addr", int'(bus.src_addr), 0, -1);
            end else if (sb.size() == 0) begin
                chk("sb_underflow", sb.size(), 1, -1);
            end else begin
                e = sb.pop_front();
                chk("src_rd", int'(bus.src_rd), int'(e.rd), e.c);
                if (bus.src_rd) chk("src_addr", int'(bus.src_addr), int'(e.addr), e.c);
                chk("vga_r", int'(bus.vga_r), int'(e.r), e.c);
                chk("vga_g", int'(bus.vga_g), int'(e.g), e.c);
                chk("vga_b", int'(bus.vga_b), int'(e.b), e.c);
                chk("vga_hs", int'(bus.vga_hs), int'(e.hs), e.c);
                chk("vga_vs", int'(bus.vga_vs), int'(e.vs), e.c);
                chk("de", int'(bus.de), int'(e.de), e.c);
                chk("frame_start", int'(bus.frame_start), int'(e.fs), e.c);
                chk("vblank", int'(bus.vblank), int'(e.vb), e.c);

                f1 = (e.ep == 1) && (e.c >= FRAME_CLK) && (e.c < 2 * FRAME_CLK);
                if (bus.src_rd) begin
                    if (int'(bus.src_addr) > max_addr) max_addr = int'(bus.src_addr);
                    if (bus.vblank) rd_in_vb++;
                    if (f1) rd_f1++;
                    if (e.ep == 1 && e.c == FRAME_CLK) last_before = prev_rd_addr;
                    prev_rd_addr = int'(bus.src_addr);
                end
                if (f1 && !bus.vga_hs && e.c < FRAME_CLK + H_TOT * CLK_DIV) begin
                    hs_low_l0++;
                    if (first_hs_low < 0) first_hs_low = e.c;
                end
                if (f1 && !bus.vga_vs) vs_low_f1++;
                if (e.ep == 1 && bus.frame_start) fs_times.push_back(e.c);
                if (e.ep == 1 && e.c == FRAME_CLK + 6 * CLK_DIV)
                    px5 = int'({bus.vga_r, bus.vga_g, bus.vga_b});
                if (e.ep == 1 && e.c == FRAME_CLK + (H_TOT + 1) * CLK_DIV)
                    px_f = int'({bus.vga_r, bus.vga_g, bus.vga_b});
            end

            if (do_final && !final_done) begin
                chk("reads_per_frame", rd_f1, 32, -1);
                chk("last_addr_of_frame", last_before, 31, -1);
                chk("max_addr", max_addr, 31, -1);
                chk("reads_in_vblank", rd_in_vb, 0, -1);
                chk("hs_low_clks_line", hs_low_l0, 12, -1);
                chk("hs_low_start", first_hs_low, 524, -1);
                chk("vs_low_clks_frame", vs_low_f1, 120, -1);
                chk("pix_x5_addr5", px5, 12'h212, -1);
                chk("pix_f81f", px_f, 12'hF0F, -1);
                chk("frame_start_count", fs_times.size(), 3, -1);
                if (fs_times.size() >= 2)
                    chk("frame_start_spacing", fs_times[1] - fs_times[0], 480, -1);
                final_done = 1;
            end
        end
    end

    // Stimulus: reset, three and a bit frames, mid-frame reset, two more frames.
    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        // Clock 1572 is tick 393 = frame 3, line 2, pixel 3, div 0.
        repeat (3 * FRAME_CLK + 33 * CLK_DIV) @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * FRAME_CLK + 100) @(posedge clk);
        do_final = 1;
        repeat (3) @(posedge clk);
        if (!final_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL final_checks: got not-run expected run");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
